// File: rtl/leaf_quad_ctrl_pkg.sv
// Shared definitions for the quad-page leaf slot sequencer: per-slot state
// codes, host command opcodes and the counter sizing helper.
// Optional watchdog is enabled by defining LEAF_QUAD_CTRL_WDOG_EN.
package leaf_quad_ctrl_pkg;

    // Per-slot lifecycle state; the encoding is visible on slot_state.
    typedef enum logic [1:0] {
        ST_RST  = 2'd0,
        ST_IDLE = 2'd1,
        ST_RUN  = 2'd2,
        ST_RSND = 2'd3
    } slot_state_t;

    // Host command opcodes carried on cmd_op.
    localparam logic [1:0] OP_RESET  = 2'b00;
    localparam logic [1:0] OP_START  = 2'b01;
    localparam logic [1:0] OP_STOP   = 2'b10;
    localparam logic [1:0] OP_RESEND = 2'b11;

    // Width of a counter able to hold the largest of the three sequence
    // lengths without wrapping.
    function automatic int cnt_width(input int rst_settle, input int resend, input int wdog);
        int m;
        m = rst_settle;
        if (resend > m) m = resend;
        if (wdog > m) m = wdog;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/leaf_slot_seq.sv
// One leaf slot's lifecycle FSM: reset/settle timing, start, stop and the
// resend pulse. All leaf-facing outputs come straight from flops.
// Optional idle watchdog is enabled by defining LEAF_QUAD_CTRL_WDOG_EN.
module leaf_slot_seq
    import leaf_quad_ctrl_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int RESEND_CYCLES = 2,
    parameter int WDOG_CYCLES   = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_strobe,
    input  logic [1:0] cmd_op,
    input  logic       dout_valid,
    output logic       leaf_reset,
    output logic       ap_start,
    output logic       resend,
    output logic       cmd_err,
    output logic       wdog_flag,
    output logic [1:0] state_code
);

    localparam int CW = cnt_width(RST_CYCLES + SETTLE_CYCLES, RESEND_CYCLES, WDOG_CYCLES);
    localparam logic [CW-1:0] CNT_MAX    = '1;
    localparam logic [CW-1:0] RST_HI_LIM = CW'(RST_CYCLES);
    localparam logic [CW-1:0] RST_END    = CW'(RST_CYCLES + SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] RSND_END   = CW'(RESEND_CYCLES - 1);

    slot_state_t   state;
    slot_state_t   state_next;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          err_next;
    logic          wdog_fire;
    logic          leaf_reset_next;
    logic          ap_start_next;
    logic          resend_next;

    assign state_code = state;

    // State register plus the registered copies of the leaf outputs.
    // NOTE: the controller reset is synchronous, so it lives inside the
    // clocked block and every flop here is given a defined reset value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_RST;
            count      <= '0;
            leaf_reset <= 1'b1;
            ap_start   <= 1'b0;
            resend     <= 1'b0;
            cmd_err    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            state      <= state_next;
            count      <= count_next;
            leaf_reset <= leaf_reset_next;
            ap_start   <= ap_start_next;
            resend     <= resend_next;
            cmd_err    <= err_next;
        end
    end

    // Next state and counter: autonomous timing first, a legal host command overrides it.
    always_comb begin
        // NOTE: defaults up front so every path assigns every signal and no
        // latch is inferred.
        state_next = state;
        count_next = count;
        err_next   = 1'b0;

        // Autonomous progress; an illegal command must not stall the timeline.
        case (state)
            ST_RST: begin
                if (count >= RST_END) begin
                    state_next = ST_IDLE;
                    count_next = '0;
                end else if (count != CNT_MAX) begin
                    count_next = count + CW'(1);
                end
            end
            ST_RSND: begin
                if (count >= RSND_END) begin
                    state_next = ST_RUN;
                    count_next = '0;
                end else if (count != CNT_MAX) begin
                    count_next = count + CW'(1);
                end
            end
            ST_RUN: begin
                if (wdog_fire) begin
                    state_next = ST_RSND;
                    count_next = '0;
                end
            end
            default: ;
        endcase

        if (cmd_strobe) begin
            case (cmd_op)
                OP_RESET: begin
                    state_next = ST_RST;
                    count_next = '0;
                end
                OP_START: begin
                    if (state == ST_IDLE) begin
                        state_next = ST_RUN;
                        count_next = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                OP_STOP: begin
                    if (state == ST_RUN) begin
                        state_next = ST_IDLE;
                        count_next = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
                default: begin
                    if (state == ST_RUN) begin
                        state_next = ST_RSND;
                        count_next = '0;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            endcase
        end
    end

    // Leaf output values for the coming cycle, derived from the next state so they can be registered.
    always_comb begin
        leaf_reset_next = (state_next == ST_RST) && (count_next < RST_HI_LIM);
        ap_start_next   = (state_next == ST_RUN) || (state_next == ST_RSND);
        resend_next     = (state_next == ST_RSND);
    end

`ifdef LEAF_QUAD_CTRL_WDOG_EN
    localparam logic [CW-1:0] WDOG_END = CW'(WDOG_CYCLES - 1);

    logic [CW-1:0] idle_cnt;
    logic          flag_q;

    // Timeout fires on the last quiet cycle of the window; any host command takes priority.
    always_comb begin
        wdog_fire = (state == ST_RUN) && !cmd_strobe && !dout_valid && (idle_cnt >= WDOG_END);
    end

    // Idle counter only runs while staying in RUN without output; the flag is cleared only by RESET.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idle_cnt <= '0;
            flag_q   <= 1'b0;
        end else begin
            if ((state == ST_RUN) && (state_next == ST_RUN) && !cmd_strobe && !dout_valid) begin
                if (idle_cnt != CNT_MAX) idle_cnt <= idle_cnt + CW'(1);
            end else begin
                idle_cnt <= '0;
            end

            if (cmd_strobe && (cmd_op == OP_RESET)) flag_q <= 1'b0;
            else if (wdog_fire)                     flag_q <= 1'b1;
        end
    end

    assign wdog_flag = flag_q;
`else
    logic unused_dout_valid;

    assign unused_dout_valid = dout_valid;
    assign wdog_fire         = 1'b0;
    assign wdog_flag         = 1'b0;
`endif

endmodule

// File: rtl/leaf_quad_ctrl.sv
// Quad-page leaf lifecycle controller: accepts host commands on a single
// valid/ready port, steers them to one of NUM_SLOTS slot sequencers and
// reports per-slot state and command errors.
// Optional per-slot watchdog is enabled by defining LEAF_QUAD_CTRL_WDOG_EN.
module leaf_quad_ctrl
    import leaf_quad_ctrl_pkg::*;
#(
    parameter int NUM_SLOTS     = 4,
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 4,
    parameter int RESEND_CYCLES = 2,
    parameter int WDOG_CYCLES   = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [$clog2(NUM_SLOTS)-1:0] cmd_slot,
    input  logic [1:0]                   cmd_op,
    output logic [NUM_SLOTS-1:0]         leaf_reset,
    output logic [NUM_SLOTS-1:0]         leaf_ap_start,
    output logic [NUM_SLOTS-1:0]         leaf_resend,
    input  logic [NUM_SLOTS-1:0]         leaf_dout_valid,
    output logic [2*NUM_SLOTS-1:0]       slot_state,
    output logic                         cmd_err,
    output logic [NUM_SLOTS-1:0]         wdog_flag
);

    localparam int SW = $clog2(NUM_SLOTS);

    logic                 accept;
    logic [NUM_SLOTS-1:0] strobe;
    logic [NUM_SLOTS-1:0] err_bits;

    // Ready is low only while held in reset; afterwards every cycle accepts a command.
    always_ff @(posedge clk) begin
        if (!reset) cmd_ready <= 1'b0;
        else        cmd_ready <= 1'b1;
    end

    assign accept = cmd_valid && cmd_ready;

    // At most one slot strobes per cycle, so at most one error bit can be set.
    assign cmd_err = |err_bits;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        assign strobe[i] = accept && (cmd_slot == SW'(i));

        leaf_slot_seq #(
            .RST_CYCLES    (RST_CYCLES),
            .SETTLE_CYCLES (SETTLE_CYCLES),
            .RESEND_CYCLES (RESEND_CYCLES),
            .WDOG_CYCLES   (WDOG_CYCLES)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .cmd_strobe (strobe[i]),
            .cmd_op     (cmd_op),
            .dout_valid (leaf_dout_valid[i]),
            .leaf_reset (leaf_reset[i]),
            .ap_start   (leaf_ap_start[i]),
            .resend     (leaf_resend[i]),
            .cmd_err    (err_bits[i]),
            .wdog_flag  (wdog_flag[i]),
            .state_code (slot_state[2*i +: 2])
        );
    end

endmodule

// File: tb/tb_leaf_quad_ctrl.sv
// Directed bench for leaf_quad_ctrl. Inputs change and outputs are sampled
// on the falling edge; the design works on the rising edge.
// Watchdog steps are built only when LEAF_QUAD_CTRL_WDOG_EN is defined.
module tb_leaf_quad_ctrl;
    import leaf_quad_ctrl_pkg::*;

`ifdef LEAF_QUAD_CTRL_WDOG_EN
    localparam int WDOG = 8;
`else
    localparam int WDOG = 1024;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_slot;
    logic [1:0] cmd_op;
    logic [3:0] leaf_reset;
    logic [3:0] leaf_ap_start;
    logic [3:0] leaf_resend;
    logic [3:0] leaf_dout_valid;
    logic [7:0] slot_state;
    logic       cmd_err;
    logic [3:0] wdog_flag;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    leaf_quad_ctrl #(
        .NUM_SLOTS     (4),
        .RST_CYCLES    (16),
        .SETTLE_CYCLES (4),
        .RESEND_CYCLES (2),
        .WDOG_CYCLES   (WDOG)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_slot        (cmd_slot),
        .cmd_op          (cmd_op),
        .leaf_reset      (leaf_reset),
        .leaf_ap_start   (leaf_ap_start),
        .leaf_resend     (leaf_resend),
        .leaf_dout_valid (leaf_dout_valid),
        .slot_state      (slot_state),
        .cmd_err         (cmd_err),
        .wdog_flag       (wdog_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one command for a single rising edge; returns at the next sample point.
    task automatic send(input logic [1:0] slot, input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_slot  = slot;
        cmd_op    = op;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
    endtask

    // Checks the common outputs in one go.
    task automatic check_outs(input string tag, input logic [3:0] rst_e, input logic [3:0] ap_e,
                              input logic [3:0] rs_e, input logic [7:0] st_e, input logic err_e);
        check({tag, ".leaf_reset"}, 32'(leaf_reset), 32'(rst_e));
        check({tag, ".ap_start"}, 32'(leaf_ap_start), 32'(ap_e));
        check({tag, ".resend"}, 32'(leaf_resend), 32'(rs_e));
        check({tag, ".slot_state"}, 32'(slot_state), 32'(st_e));
        check({tag, ".cmd_err"}, 32'(cmd_err), 32'(err_e));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset           = 1'b0;
        cmd_valid       = 1'b0;
        cmd_slot        = 2'd0;
        cmd_op          = 2'b00;
        leaf_dout_valid = 4'hf;

        // Held in reset.
        repeat (3) @(negedge clk);
        check_outs("reset", 4'hf, 4'h0, 4'h0, 8'h00, 1'b0);
        check("reset.cmd_ready", 32'(cmd_ready), 32'd0);
        check("reset.wdog_flag", 32'(wdog_flag), 32'd0);

        // Release: leaf_reset high for 16 cycles, RST for 20, then all IDLE.
        reset = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            check($sformatf("rel%0d.leaf_reset", i), 32'(leaf_reset), (i < 16) ? 32'hf : 32'h0);
            check($sformatf("rel%0d.slot_state", i), 32'(slot_state), (i < 20) ? 32'h00 : 32'h55);
            check($sformatf("rel%0d.cmd_ready", i), 32'(cmd_ready), 32'd1);
        end

        // START / STOP slot 2.
        send(2'd2, OP_START);
        check_outs("start2", 4'h0, 4'b0100, 4'h0, 8'h65, 1'b0);
        send(2'd2, OP_STOP);
        check_outs("stop2", 4'h0, 4'h0, 4'h0, 8'h55, 1'b0);

        // RESEND slot 1 while running: two resend cycles, ap_start held.
        send(2'd1, OP_START);
        check_outs("start1", 4'h0, 4'b0010, 4'h0, 8'h59, 1'b0);
        send(2'd1, OP_RESEND);
        check_outs("rsnd1.c0", 4'h0, 4'b0010, 4'b0010, 8'h5d, 1'b0);
        @(negedge clk);
        check_outs("rsnd1.c1", 4'h0, 4'b0010, 4'b0010, 8'h5d, 1'b0);
        @(negedge clk);
        check_outs("rsnd1.done", 4'h0, 4'b0010, 4'h0, 8'h59, 1'b0);

        // START in RST is illegal: one-cycle error, nothing else moves.
        send(2'd0, OP_RESET);
        check_outs("reset0", 4'b0001, 4'b0010, 4'h0, 8'h58, 1'b0);
        send(2'd0, OP_START);
        check_outs("start0_in_rst", 4'b0001, 4'b0010, 4'h0, 8'h58, 1'b1);
        @(negedge clk);
        check_outs("start0_err_gone", 4'b0001, 4'b0010, 4'h0, 8'h58, 1'b0);

        // RESET slot 3 during its resend pulse.
        send(2'd3, OP_START);
        check_outs("start3", 4'b0001, 4'b1010, 4'h0, 8'h98, 1'b0);
        send(2'd3, OP_RESEND);
        check_outs("rsnd3", 4'b0001, 4'b1010, 4'b1000, 8'hd8, 1'b0);
        send(2'd3, OP_RESET);
        check_outs("reset3_in_rsnd", 4'b1001, 4'b0010, 4'h0, 8'h18, 1'b0);

        // More illegal pairs: STOP in IDLE, RESEND in IDLE, STOP in RSND.
        send(2'd2, OP_STOP);
        check_outs("stop2_in_idle", 4'b1001, 4'b0010, 4'h0, 8'h18, 1'b1);
        send(2'd2, OP_RESEND);
        check_outs("rsnd2_in_idle", 4'b1001, 4'b0010, 4'h0, 8'h18, 1'b1);
        send(2'd1, OP_RESEND);
        check_outs("rsnd1b", 4'b1001, 4'b0010, 4'b0010, 8'h1c, 1'b0);
        send(2'd1, OP_STOP);
        check_outs("stop1_in_rsnd", 4'b1001, 4'b0010, 4'b0010, 8'h1c, 1'b1);
        @(negedge clk);
        check_outs("rsnd1b.done", 4'b1001, 4'b0010, 4'h0, 8'h18, 1'b0);

        // Controller reset mid-sequence returns everything to the reset level.
        reset = 1'b0;
        @(negedge clk);
        check_outs("midreset", 4'hf, 4'h0, 4'h0, 8'h00, 1'b0);
        check("midreset.cmd_ready", 32'(cmd_ready), 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check_outs("rerelease", 4'h0, 4'h0, 4'h0, 8'h55, 1'b0);
        check("rerelease.wdog_flag", 32'(wdog_flag), 32'd0);

`ifdef LEAF_QUAD_CTRL_WDOG_EN
        // Slot 0 runs with no output for 8 cycles: watchdog resend, sticky flag.
        leaf_dout_valid = 4'he;
        send(2'd0, OP_START);
        check_outs("wd.start0", 4'h0, 4'b0001, 4'h0, 8'h56, 1'b0);
        repeat (7) @(negedge clk);
        check("wd.quiet8.state", 32'(slot_state), 32'h56);
        check("wd.quiet8.flag", 32'(wdog_flag), 32'h0);
        @(negedge clk);
        check_outs("wd.fire", 4'h0, 4'b0001, 4'b0001, 8'h57, 1'b0);
        check("wd.fire.flag", 32'(wdog_flag), 32'b0001);
        leaf_dout_valid = 4'hf;
        @(negedge clk);
        check("wd.rsnd2.resend", 32'(leaf_resend), 32'b0001);
        @(negedge clk);
        check_outs("wd.back_run", 4'h0, 4'b0001, 4'h0, 8'h56, 1'b0);
        check("wd.sticky", 32'(wdog_flag), 32'b0001);
        send(2'd0, OP_RESET);
        check_outs("wd.reset0", 4'b0001, 4'h0, 4'h0, 8'h54, 1'b0);
        check("wd.cleared", 32'(wdog_flag), 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/leaf_quad_ctrl.md
Name: leaf_quad_ctrl

Overview:
- Per-slot lifecycle sequencer for the four leaf slots of a quad page.
- Generates the leaf-side reset, ap_start and resend for each slot from host commands on a single valid/ready command port.
- Sits between the host/config register block and the quad's leaf slots; reports per-slot state.
- Guarantees minimum reset width and settle time before start.

Parameters:
- NUM_SLOTS, 4, number of leaf slots sequenced; the slot-index width is $clog2(NUM_SLOTS).
- RST_CYCLES, 16, cycles leaf_reset is held high per reset sequence.
- SETTLE_CYCLES, 4, cycles after leaf_reset falls before the slot reaches IDLE.
- RESEND_CYCLES, 2, width of the leaf_resend pulse.
- WDOG_CYCLES, 1024, watchdog timeout (optional feature only).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_slot  in  $clog2(NUM_SLOTS)  target slot.
- cmd_op  in  2  00=RESET, 01=START, 10=STOP, 11=RESEND.
- leaf_reset  out  NUM_SLOTS  per-slot leaf reset, active-high.
- leaf_ap_start  out  NUM_SLOTS  per-slot ap_start.
- leaf_resend  out  NUM_SLOTS  per-slot resend.
- leaf_dout_valid  in  NUM_SLOTS  bit 48 of each slot's dout_leaf_interface2bft; used only by the watchdog.
- slot_state  out  2*NUM_SLOTS  per-slot state code, slot i at bits [2i+1:2i].
- cmd_err  out  1  one-cycle pulse when an accepted command is illegal in the slot's current state.
- wdog_flag  out  NUM_SLOTS  sticky per-slot timeout flag (optional feature only).

Behaviour:
- Reset level: reset sampled low at a clk edge while reset is low gives:
  - leaf_reset all 1, leaf_ap_start 0, leaf_resend 0.
  - cmd_ready 0, cmd_err 0, wdog_flag 0.
  - every slot in RST with its counter cleared.
- Reset release: cmd_ready goes 1 on the first cycle after release and stays 1 (zero-wait acceptance, one command per cycle).
- Per-slot states (slot_state code): RST=0, IDLE=1, RUN=2, RSND=3.
- RST state:
  - Counter increments each cycle.
  - leaf_reset=1 while count < RST_CYCLES, 0 afterwards.
  - The slot enters IDLE when count reaches RST_CYCLES+SETTLE_CYCLES-1, i.e. it is in RST for RST_CYCLES+SETTLE_CYCLES cycles total.
- Legal commands, all taking effect on registered outputs at cycle N+1 after acceptance at cycle N:
  - RESET from any state → RST, counter restarts at 0. leaf_reset=1, ap_start=0, resend=0 at N+1.
  - START from IDLE → RUN, ap_start=1.
  - STOP from RUN → IDLE, ap_start=0.
  - RESEND from RUN → RSND, resend=1 for exactly RESEND_CYCLES cycles with ap_start held 1, then back to RUN.
- Illegal commands: any other state/op pair has no state change and cmd_err=1 at N+1. Examples: START in RST/RUN/RSND; STOP in IDLE; RESEND outside RUN.
- RESET in RSND: resend drops at N+1. RESET overrides everything, including the watchdog.
- Slot independence: commands to one slot never affect other slots' outputs or counters.
- Controller reset mid-sequence: all slots return to the reset-level state above regardless of progress.
- Counter width: $clog2(max(RST_CYCLES+SETTLE_CYCLES, RESEND_CYCLES, WDOG_CYCLES)+1). Counters saturate and never wrap.
- Glitch-free outputs: leaf_reset, leaf_ap_start and leaf_resend are driven directly from flops.

Optional Feature:
- Macro: LEAF_QUAD_CTRL_WDOG_EN.
- Defined:
  - In RUN, a per-slot idle counter increments each cycle that leaf_dout_valid[i]=0 and clears when it is 1.
  - When the counter reaches WDOG_CYCLES, wdog_flag[i] sets (sticky until that slot's RESET command or controller reset) and the slot enters RSND automatically, as if it had received RESEND.
  - A host command accepted in the same cycle wins over the watchdog, and the idle counter clears.
  - The idle counter clears on every entry to RUN.
- Undefined: no idle counter, wdog_flag tied 0, leaf_dout_valid unused.

Decomposition:
- Package leaf_quad_ctrl_pkg holds:
  - state enum {ST_RST, ST_IDLE, ST_RUN, ST_RSND};
  - op constants OP_RESET, OP_START, OP_STOP, OP_RESEND;
  - the counter-width function.
- Sub-module leaf_slot_seq: one slot's FSM, counters and outputs, instantiated NUM_SLOTS times.
- The top decodes cmd_slot into a per-slot one-hot command strobe and ORs the per-slot error bits into cmd_err.

Test Plan:
- Release reset, idle all slots → leaf_reset=4'b1111 for 16 cycles then 0, slot_state=0 for 20 cycles, then slot_state=8'h55, cmd_ready=1.
- START slot 2 at cycle N → leaf_ap_start=4'b0100 at N+1, slot_state[5:4]=2; STOP slot 2 → ap_start 0 at next+1, state 1.
- RESEND slot 1 while running → leaf_resend[1]=1 for exactly 2 cycles, ap_start[1] held 1, state 3 then 2.
- START slot 0 while in RST → cmd_err pulses 1 cycle, no output change.
- RESET slot 3 during its resend pulse → resend[3]=0 and leaf_reset[3]=1 next cycle, other slots unchanged.
- With LEAF_QUAD_CTRL_WDOG_EN, WDOG_CYCLES=8: slot 0 RUN, leaf_dout_valid[0]=0 for 8 cycles → wdog_flag[0]=1 and a 2-cycle resend; RESET slot 0 clears the flag.
